// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounced one-hot keypad encoder with BCD entry accumulator
module keypad_entry #(
  parameter int KEYS      = 10,
  parameter int DEBOUNCE  = 4,
  parameter int DIGITS    = 4,
  parameter int OVERWRITE = 1
) (
  input  logic                         clock,
  input  logic                         clearn,
  input  logic [KEYS-1:0]              keyboard,
  input  logic                         enablen,
  input  logic                         entry_clrn,
  output logic [3:0]                   bcd,
  output logic                         valid_data,
  output logic                         multi_key,
  output logic [4*DIGITS-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int NW = $clog2(DIGITS + 1);
  localparam int EW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ctr_q, ctr_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic            multi_q, multi_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [NW-1:0]   count_q, count_d;

  logic [3:0]      key_idx;
  logic            any_key;
  logic            many_keys;
  logic            none;
  logic            press_ok;
  logic            accept;
  logic            full_w;
  logic [EW-1:0]   entry_shift;

  // Classify the sample: key_idx is only meaningful when exactly one line is set.
  always_comb begin
    key_idx   = '0;
    any_key   = 1'b0;
    many_keys = 1'b0;
    for (int i = 0; i < KEYS; i++) begin
      if (keyboard[i]) begin
        if (any_key) many_keys = 1'b1;
        any_key = 1'b1;
        key_idx = 4'(i);
      end
    end
  end

  assign none     = ~any_key;
  assign press_ok = any_key & ~many_keys & ~enablen;
  assign full_w   = (count_q == NW'(DIGITS));

  generate
    if (DIGITS == 1) begin : g_one
      assign entry_shift = key_idx;
    end else begin : g_many
      assign entry_shift = {entry_q[EW-5:0], key_idx};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!clearn) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      cand_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      entry_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      cand_q  <= cand_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  // ctr counts press samples in PRESS_DB and release samples in RELEASE_DB.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_ok) begin
          cand_d = key_idx;
          ctr_d  = CW'(1);
          if (DEBOUNCE == 1) begin
            accept  = 1'b1;
            state_d = HELD;
          end else begin
            state_d = PRESS_DB;
          end
        end
      end
      PRESS_DB: begin
        if (press_ok && key_idx == cand_q) begin
          ctr_d = ctr_q + CW'(1);
          if (ctr_d == CW'(DEBOUNCE)) begin
            accept  = 1'b1;
            state_d = HELD;
          end
        end else begin
          ctr_d   = '0;
          state_d = IDLE;
        end
      end
      HELD: begin
        if (none) begin
          ctr_d   = CW'(1);
          state_d = (DEBOUNCE == 1) ? IDLE : RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (none) begin
          ctr_d = ctr_q + CW'(1);
          if (ctr_d == CW'(DEBOUNCE)) state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry clear wins over a simultaneous accept, but the pulse and code still go out.
  always_comb begin
    bcd_d   = bcd_q;
    valid_d = accept;
    multi_d = many_keys & ~enablen;
    entry_d = entry_q;
    count_d = count_q;
    if (accept) begin
      bcd_d = key_idx;
      if (!full_w) begin
        entry_d = entry_shift;
        count_d = count_q + NW'(1);
      end else if (OVERWRITE != 0) begin
        entry_d = entry_shift;
      end
    end
    if (!entry_clrn) begin
      entry_d = '0;
      count_d = '0;
    end
  end

  assign bcd        = bcd_q;
  assign valid_data = valid_q;
  assign multi_key  = multi_q;
  assign entry      = entry_q;
  assign count      = count_q;
  assign full       = full_w;

endmodule
